// File: rtl/xpb_table_gen_if.sv
// rtl/xpb_table_gen_if.sv - request/response and table-write bundle for xpb_table_gen
// master drives the request side; slave is the generator.
interface xpb_table_gen_if #(
  parameter int WIDTH  = 1024,
  parameter int ADDR_W = 5
) ();
  logic              start;
  logic [WIDTH-1:0]  base;
  logic [WIDTH-1:0]  modulus;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              done;
  logic              err;

  modport master (
    output start, base, modulus,
    input  busy, wr_en, wr_addr, wr_data, done, err
  );

  modport slave (
    input  start, base, modulus,
    output busy, wr_en, wr_addr, wr_data, done, err
  );
endinterface

// File: rtl/xpb_table_gen.sv
// rtl/xpb_table_gen.sv - generates table entry j = (j*base) mod M, one write per cycle
// Optional operand range check: define XPB_GEN_RANGE_CHECK_EN.
module xpb_table_gen #(
  parameter int WIDTH  = 1024,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  xpb_table_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_base;
  logic [WIDTH-1:0]  r_mod;
  logic [WIDTH-1:0]  r_acc;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;
  logic              r_wr_en;
  logic              r_done;

  logic [WIDTH:0]    w_sum;
  logic              w_ge;
  logic [WIDTH-1:0]  w_acc_next;

  // The low WIDTH bits of the subtraction are exact because sum - M < 2**WIDTH
  // whenever acc, base < M.
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_base};
  assign w_ge       = (w_sum >= {1'b0, r_mod});
  assign w_acc_next = w_ge ? (w_sum[WIDTH-1:0] - r_mod) : w_sum[WIDTH-1:0];

`ifdef XPB_GEN_RANGE_CHECK_EN
  logic r_err;
  logic w_range_bad;

  assign w_range_bad = (bus.base >= bus.modulus) || (bus.modulus == '0);
  assign bus.err     = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy    = r_busy;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_idx;
  assign bus.wr_data = r_acc;
  assign bus.done    = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_mod   <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
`ifdef XPB_GEN_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_base <= bus.base;
            r_mod  <= bus.modulus;
            r_acc  <= '0;
            r_idx  <= '0;
            r_busy <= 1'b1;
`ifdef XPB_GEN_RANGE_CHECK_EN
            if (w_range_bad) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_err   <= 1'b0;
              r_wr_en <= 1'b1;
              r_state <= RUN;
            end
`else
            r_wr_en <= 1'b1;
            r_state <= RUN;
`endif
          end
        end
        RUN: begin
          // wr_addr/wr_data already present the current entry; advance to the next.
          r_acc <= w_acc_next;
          r_idx <= r_idx + 1'b1;
          if (r_idx == {ADDR_W{1'b1}}) begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// tb/tb_xpb_table_gen.sv - directed-vector self-checking bench for xpb_table_gen
// Optional range-check vectors run when XPB_GEN_RANGE_CHECK_EN is defined.
module tb_xpb_table_gen;

  localparam int W  = 1024;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  xpb_table_gen_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  xpb_table_gen #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // kind: 0 data=j, 1 data=3j mod 7, 2 data=M-j (j>0), 3 data=2j mod 5.
  function automatic logic [W-1:0] exp_entry(input int kind, input int j, input logic [W-1:0] m);
    logic [W-1:0] e;
    case (kind)
      0:       e = W'(j);
      1:       e = W'((3 * j) % 7);
      2:       e = (j == 0) ? '0 : (m - W'(j));
      default: e = W'((2 * j) % 5);
    endcase
    return e;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_table(input string tag, input logic [W-1:0] b, input logic [W-1:0] m,
                           input int kind);
    bus.base    = b;
    bus.modulus = m;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.base    = ~b;
    bus.modulus = '0;
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      check($sformatf("%s_wr_en_%0d", tag, j), W'(bus.wr_en), W'(1));
      check($sformatf("%s_addr_%0d", tag, j), W'(bus.wr_addr), W'(j));
      check($sformatf("%s_data_%0d", tag, j), bus.wr_data, exp_entry(kind, j, m));
      check($sformatf("%s_busy_%0d", tag, j), W'(bus.busy), W'(1));
      check($sformatf("%s_done_%0d", tag, j), W'(bus.done), W'(0));
      check($sformatf("%s_err_%0d", tag, j), W'(bus.err), W'(0));
    end
    @(negedge clk);
    check({tag, "_fin_done"}, W'(bus.done), W'(1));
    check({tag, "_fin_wr_en"}, W'(bus.wr_en), W'(0));
    check({tag, "_fin_busy"}, W'(bus.busy), W'(1));
    @(negedge clk);
    check({tag, "_idle_done"}, W'(bus.done), W'(0));
    check({tag, "_idle_busy"}, W'(bus.busy), W'(0));
    check({tag, "_idle_wr_en"}, W'(bus.wr_en), W'(0));
  endtask

  initial begin
    logic [W-1:0] m1;
    logic [W-1:0] m3;
    int           p;

    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.base    = '0;
    bus.modulus = '0;

    m1       = '0;
    m1[W-1]  = 1'b1;
    m1[0]    = 1'b1;
    m3       = '1;
    m3       = m3 - W'(188);

    #1;
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_wr_en", W'(bus.wr_en), W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_err", W'(bus.err), W'(0));
    check("rst_addr", W'(bus.wr_addr), W'(0));
    check("rst_data", bus.wr_data, '0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_table("unit", W'(1), m1, 0);
    run_table("b3m7", W'(3), W'(7), 1);
    run_table("carry", m3 - W'(1), m3, 2);

    // Abort mid-run with reset, then regenerate from scratch.
    bus.base    = W'(3);
    bus.modulus = W'(7);
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      check($sformatf("abort_addr_%0d", j), W'(bus.wr_addr), W'(j));
      check($sformatf("abort_wr_en_%0d", j), W'(bus.wr_en), W'(1));
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_wr_en_now", W'(bus.wr_en), W'(0));
    check("abort_busy_now", W'(bus.busy), W'(0));
    check("abort_done_now", W'(bus.done), W'(0));
    check("abort_addr_now", W'(bus.wr_addr), W'(0));
    check("abort_data_now", bus.wr_data, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_hold_wr_en_%0d", k), W'(bus.wr_en), W'(0));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("abort_idle_wr_en_%0d", k), W'(bus.wr_en), W'(0));
      check($sformatf("abort_idle_busy_%0d", k), W'(bus.busy), W'(0));
    end
    run_table("regen", W'(3), W'(7), 1);

    // start held high: 32 writes, done, one IDLE cycle, repeat.
    bus.base    = W'(3);
    bus.modulus = W'(7);
    bus.start   = 1'b1;
    for (int c = 1; c <= 103; c++) begin
      @(negedge clk);
      p = (c == 103) ? 33 : ((c - 1) % 34);
      check($sformatf("held_wr_en_%0d", c), W'(bus.wr_en), W'(p < 32));
      check($sformatf("held_done_%0d", c), W'(bus.done), W'(p == 32));
      check($sformatf("held_busy_%0d", c), W'(bus.busy), W'(p <= 32));
      if (p < 32) begin
        check($sformatf("held_addr_%0d", c), W'(bus.wr_addr), W'(p));
        check($sformatf("held_data_%0d", c), bus.wr_data, W'((3 * p) % 7));
      end
      if (c == 80) bus.start = 1'b0;
    end

`ifdef XPB_GEN_RANGE_CHECK_EN
    bus.base    = W'(5);
    bus.modulus = W'(5);
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("rc_done", W'(bus.done), W'(1));
    check("rc_wr_en", W'(bus.wr_en), W'(0));
    check("rc_err", W'(bus.err), W'(1));
    check("rc_busy", W'(bus.busy), W'(1));
    @(negedge clk);
    check("rc_idle_done", W'(bus.done), W'(0));
    check("rc_idle_busy", W'(bus.busy), W'(0));
    check("rc_sticky_err", W'(bus.err), W'(1));
    check("rc_idle_wr_en", W'(bus.wr_en), W'(0));
    run_table("rc_ok", W'(2), W'(5), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xpb_table_gen.md
XPB_TABLE_GEN -- requirements
Module: xpb_table_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, operand and table-entry width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, table address width; table depth = 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to generate a table; sampled only in IDLE.
REQ-006 SHALL have port base  input  WIDTH  table step value, captured on accepted start.
REQ-007 SHALL have port modulus  input  WIDTH  reduction modulus M, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done is asserted, inclusive.
REQ-009 SHALL have port wr_en  output  1  table write strobe.
REQ-010 SHALL have port wr_addr  output  ADDR_W  table write address.
REQ-011 SHALL have port wr_data  output  WIDTH  table write data.
REQ-012 SHALL have port done  output  1  single-cycle completion pulse.
REQ-013 SHALL have port err  output  1  sticky range-check error flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIN; IDLE->RUN on start, RUN->FIN after last entry written, FIN->IDLE unconditionally.
REQ-015 On start in IDLE SHALL latch base and modulus, clear accumulator acc to 0 and index idx to 0.
REQ-016 start asserted while not in IDLE SHALL be ignored with no effect on state, registers or outputs.
REQ-017 In RUN each cycle SHALL assert wr_en with wr_addr=idx, wr_data=acc, then update acc <= (acc + base) mod M and idx <= idx+1.
REQ-018 Modular add SHALL form a WIDTH+1-bit sum and subtract M once iff sum >= M; result valid for acc, base < M.
REQ-019 Entry j SHALL equal (j*base) mod M for j = 0 .. 2**ADDR_W-1; entry 0 = 0, entry 1 = base.
REQ-020 RUN SHALL last exactly 2**ADDR_W cycles, one write per cycle, no bubbles; idx wraps to 0 after the last write and no extra write occurs.
REQ-021 Latency: start accepted at edge t -> writes at cycles t+1 .. t+2**ADDR_W, done high at cycle t+2**ADDR_W+1 (32 writes, done at t+33 by default).
REQ-022 wr_en SHALL be low in IDLE and FIN; wr_addr/wr_data are don't-care when wr_en low but SHALL not toggle X.
REQ-023 done SHALL be high only in FIN, for exactly one cycle; start in the FIN cycle is ignored; start in the next IDLE cycle is accepted.
REQ-024 Changes to base/modulus inputs after the accepting edge SHALL not affect the table in progress.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, busy=0, wr_en=0, done=0, err=0, wr_addr=0, wr_data=0, acc=0, idx=0.
REQ-026 Reset during RUN SHALL abort generation; no further writes after rst_n falls; a new start is required after release.
REQ-027 First start accepted SHALL be on the first rising edge with rst_n high.

Configuration
REQ-028 Macro XPB_GEN_RANGE_CHECK_EN SHALL, when defined, compare captured base against modulus on start: if base >= modulus or modulus == 0, set err, skip RUN (no writes), go directly to FIN (done pulses one cycle after start); err stays set until next accepted start with valid operands clears it, or reset.
REQ-029 Without XPB_GEN_RANGE_CHECK_EN, err SHALL be tied 0, no comparison logic shall exist, and out-of-range operands give unspecified table contents but identical timing.

Verification
REQ-030 base=1, M=2**1023+1 -> 32 writes, addr 0..31, data = addr, done at t+33.
REQ-031 base=3, M=7 -> data sequence 0,3,6,2,5,1,4,0,3,... for addr 0..31; entry 31 = 93 mod 7 = 2.
REQ-032 base=M-1, M=2**1024-189 -> entry j = M-j for j=1..31, entry 0 = 0 (exercises WIDTH+1 carry).
REQ-033 rst_n pulsed low after write of addr 10 -> wr_en low same cycle, busy/done 0, no write to addr 11; fresh start regenerates from addr 0.
REQ-034 start held high continuously for 80 cycles -> table runs back-to-back with one IDLE cycle between FIN and next RUN; mid-run start pulses do not restart idx.
REQ-035 With XPB_GEN_RANGE_CHECK_EN: base=M=5 -> err=1, zero writes, done at t+1; then base=2, M=5 -> err cleared, normal 32-entry table.
